// File: rtl/data_memory_mmio.sv
// Word-addressed data memory with a 5-word MMIO window: seven-segment
// registers, synchronised buttons with sticky W1C edge flags, cycle counter.
//
// Ports:
//   clk        core clock; all state updates on the falling edge
//   rst_n      asynchronous active-low reset (RAM contents are kept)
//   d_addr     word address
//   data_in    write data
//   wr         write strobe
//   byte_en    per-byte write enable
//   data_out   combinational read data
//   buttons_in raw asynchronous buttons
//   seg_out    seven-segment data register
//   seg_en     seven-segment enable register
//   btn_irq    OR of all sticky button-edge flags
module data_memory_mmio #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 8,
    parameter int BTN_W       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int MMIO_BASE   = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_W-1:0]     d_addr,
    input  logic [DATA_W-1:0]     data_in,
    input  logic                  wr,
    input  logic [DATA_W/8-1:0]   byte_en,
    output logic [DATA_W-1:0]     data_out,
    input  logic [BTN_W-1:0]      buttons_in,
    output logic [DATA_W-1:0]     seg_out,
    output logic [DATA_W-1:0]     seg_en,
    output logic                  btn_irq
);

    localparam int NB = DATA_W / 8;
    localparam int DEPTH = 2 ** ADDR_W;

    localparam logic [ADDR_W-1:0] A_SEG  = ADDR_W'(MMIO_BASE);
    localparam logic [ADDR_W-1:0] A_SEN  = ADDR_W'(MMIO_BASE + 1);
    localparam logic [ADDR_W-1:0] A_LVL  = ADDR_W'(MMIO_BASE + 2);
    localparam logic [ADDR_W-1:0] A_EDGE = ADDR_W'(MMIO_BASE + 3);
    localparam logic [ADDR_W-1:0] A_CYC  = ADDR_W'(MMIO_BASE + 4);

    logic [DATA_W-1:0] r_ram [DEPTH];
    logic [DATA_W-1:0] r_seg_data;
    logic [DATA_W-1:0] r_seg_en;
    logic [BTN_W-1:0]  r_btn_edge;
    logic [DATA_W-1:0] r_cycle;
    logic [SYNC_STAGES-1:0][BTN_W-1:0] r_sync;
    logic [BTN_W-1:0]  r_prev;

    logic [DATA_W-1:0] w_mask;
    logic [DATA_W-1:0] w_wmask;
    logic              w_sel_seg;
    logic              w_sel_sen;
    logic              w_sel_lvl;
    logic              w_sel_edge;
    logic              w_sel_cyc;
    logic              w_io;
    logic [BTN_W-1:0]  w_level;
    logic [BTN_W-1:0]  w_rise;
    logic [BTN_W-1:0]  w_clr;
    logic              w_cyc_ld;
    logic [DATA_W-1:0] w_rdata;

    always_comb begin
        w_mask = '0;
        for (int i = 0; i < NB; i++) begin
            w_mask[8*i +: 8] = {8{byte_en[i]}};
        end
    end

    assign w_wmask    = wr ? w_mask : '0;

    assign w_sel_seg  = (d_addr == A_SEG);
    assign w_sel_sen  = (d_addr == A_SEN);
    assign w_sel_lvl  = (d_addr == A_LVL);
    assign w_sel_edge = (d_addr == A_EDGE);
    assign w_sel_cyc  = (d_addr == A_CYC);
    assign w_io = w_sel_seg | w_sel_sen | w_sel_lvl
                | w_sel_edge | w_sel_cyc;

    assign w_level = r_sync[SYNC_STAGES-1];
    assign w_rise  = w_level & ~r_prev;
    assign w_clr   = w_sel_edge ? (data_in[BTN_W-1:0] & w_wmask[BTN_W-1:0])
                                : '0;
    // A load with every lane disabled is a no-op, so counting continues.
    assign w_cyc_ld = w_sel_cyc & (|w_wmask);

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seg_data <= '0;
            r_seg_en   <= '0;
            r_btn_edge <= '0;
            r_cycle    <= '0;
            r_sync     <= '0;
            r_prev     <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], buttons_in};
            r_prev <= w_level;
            // Set is OR-ed after the clear so a same-edge rise wins.
            r_btn_edge <= (r_btn_edge & ~w_clr) | w_rise;
            if (w_sel_seg)
                r_seg_data <= (r_seg_data & ~w_wmask) | (data_in & w_wmask);
            if (w_sel_sen)
                r_seg_en <= (r_seg_en & ~w_wmask) | (data_in & w_wmask);
            if (w_cyc_ld)
                r_cycle <= (r_cycle & ~w_wmask) | (data_in & w_wmask);
            else
                r_cycle <= r_cycle + 1'b1;
        end
    end

    // RAM has no reset; a write landing while reset is asserted is dropped.
    always_ff @(negedge clk) begin
        if (rst_n && wr && !w_io) begin
            for (int i = 0; i < NB; i++) begin
                if (byte_en[i])
                    r_ram[d_addr][8*i +: 8] <= data_in[8*i +: 8];
            end
        end
    end

    always_comb begin
        w_rdata = '0;
        unique case (1'b1)
            w_sel_seg:  w_rdata = r_seg_data;
            w_sel_sen:  w_rdata = r_seg_en;
            w_sel_lvl:  w_rdata[BTN_W-1:0] = w_level;
            w_sel_edge: w_rdata[BTN_W-1:0] = r_btn_edge;
            w_sel_cyc:  w_rdata = r_cycle;
            default:    w_rdata = r_ram[d_addr];
        endcase
    end

    assign data_out = w_rdata;
    assign seg_out  = r_seg_data;
    assign seg_en   = r_seg_en;
    assign btn_irq  = |r_btn_edge;

endmodule

// File: tb/tb_data_memory_mmio.sv
// Self-checking bench for data_memory_mmio: directed scenarios plus
// randomized traffic against a history-based reference model.
module tb_data_memory_mmio;

    localparam int S = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  d_addr = '0;
    logic [31:0] data_in = '0;
    logic        wr = 1'b0;
    logic [3:0]  byte_en = '0;
    logic [31:0] data_out;
    logic [15:0] buttons_in = '0;
    logic [31:0] seg_out;
    logic [31:0] seg_en;
    logic        btn_irq;

    int n_chk = 0;
    int n_err = 0;

    data_memory_mmio dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .d_addr     (d_addr),
        .data_in    (data_in),
        .wr         (wr),
        .byte_en    (byte_en),
        .data_out   (data_out),
        .buttons_in (buttons_in),
        .seg_out    (seg_out),
        .seg_en     (seg_en),
        .btn_irq    (btn_irq)
    );

    initial forever #5 clk = ~clk;

    // Reference model: buttons seen at each falling edge since reset.
    logic [31:0] m_ram [256];
    logic [31:0] m_kn  [256];
    logic [31:0] m_seg = '0;
    logic [31:0] m_sen = '0;
    logic [15:0] m_edge = '0;
    logic [31:0] m_cyc = '0;
    logic [15:0] hist [$];

    function automatic logic [15:0] lvl(int back);
        int idx;
        idx = hist.size() - S - back;
        return (idx >= 0) ? hist[idx] : 16'h0;
    endfunction

    task automatic model_step();
        logic [15:0] rise, clr;
        logic [31:0] m;
        int a;
        if (!rst_n) begin
            m_seg = '0; m_sen = '0; m_edge = '0; m_cyc = '0;
            hist.delete();
            return;
        end
        rise = lvl(0) & ~lvl(1);
        for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{byte_en[i]}};
        a = int'(d_addr);
        clr = (wr && a == 3) ? (data_in[15:0] & m[15:0]) : 16'h0;
        m_edge = (m_edge & ~clr) | rise;
        if (wr && a == 4 && m != 0) m_cyc = (m_cyc & ~m) | (data_in & m);
        else m_cyc = m_cyc + 1;
        if (wr) begin
            case (a)
                0: m_seg = (m_seg & ~m) | (data_in & m);
                1: m_sen = (m_sen & ~m) | (data_in & m);
                2, 3, 4: ;
                default: begin
                    m_ram[a] = (m_ram[a] & ~m) | (data_in & m);
                    m_kn[a]  = m_kn[a] | m;
                end
            endcase
        end
        hist.push_back(buttons_in);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            m_ram[i] = '0;
            m_kn[i]  = '0;
        end
        forever begin
            @(negedge clk or negedge rst_n);
            model_step();
        end
    end

    function automatic logic [31:0] m_read(int a);
        case (a)
            0: return m_seg;
            1: return m_sen;
            2: return {16'h0, lvl(0)};
            3: return {16'h0, m_edge};
            4: return m_cyc;
            default: return m_ram[a];
        endcase
    endfunction

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #2;
    endtask

    task automatic write(int a, logic [31:0] d, logic [3:0] be);
        @(posedge clk);
        #1;
        d_addr = 8'(a); data_in = d; byte_en = be; wr = 1'b1;
        @(negedge clk);
        #1;
        wr = 1'b0; byte_en = '0;
    endtask

    task automatic rd(string tag, int a, logic [31:0] exp);
        wr = 1'b0;
        d_addr = 8'(a);
        #1;
        check(tag, data_out, exp);
    endtask

    initial begin
        int a;
        logic [31:0] kn;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset state and counter start
        check("rst_seg_out", seg_out, 32'h0);
        check("rst_seg_en", seg_en, 32'h0);
        check("rst_irq", {31'h0, btn_irq}, 32'h0);
        step(); rd("cyc1", 4, 32'd1);
        step(); rd("cyc2", 4, 32'd2);
        step(); rd("cyc3", 4, 32'd3);

        // Byte lanes and shadowed RAM
        write(10, 32'hAABBCCDD, 4'hF);
        write(10, 32'h11223344, 4'b0101);
        rd("ram_lanes", 10, 32'hAA22CC44);
        write(2, 32'hFFFFFFFF, 4'hF);
        rd("lvl_ro", 2, 32'h0);

        // Button sync and edge capture
        @(posedge clk); #1 buttons_in = 16'h0001;
        step();
        rd("lvl_1edge", 2, 32'h0);
        step();
        rd("lvl_2edge", 2, 32'h1);
        rd("edge_2edge", 3, 32'h0);
        step();
        rd("edge_3edge", 3, 32'h1);
        check("irq_set", {31'h0, btn_irq}, 32'h1);
        @(posedge clk); #1 buttons_in = 16'h0000;
        repeat (4) step();
        rd("edge_sticky", 3, 32'h1);

        // W1C and set-wins
        write(3, 32'h1, 4'hF);
        rd("edge_clr", 3, 32'h0);
        check("irq_clr", {31'h0, btn_irq}, 32'h0);
        @(posedge clk); #1 buttons_in = 16'h0001;
        step();
        step();
        write(3, 32'h1, 4'hF);
        rd("edge_setwins", 3, 32'h1);

        // Cycle counter load and wrap
        write(4, 32'hFFFFFFFE, 4'hF);
        rd("cyc_ld", 4, 32'hFFFFFFFE);
        step(); rd("cyc_max", 4, 32'hFFFFFFFF);
        step(); rd("cyc_wrap", 4, 32'h0);
        write(4, 32'h12345600, 4'hF);
        write(4, 32'h000000AB, 4'b0001);
        rd("cyc_lane", 4, 32'h123456AB);

        // Mid-operation reset
        write(0, 32'h5A5A5A5A, 4'hF);
        write(1, 32'h0000000F, 4'hF);
        check("seg_wr", seg_out, 32'h5A5A5A5A);
        check("sen_wr", seg_en, 32'h0000000F);
        @(posedge clk); #1;
        d_addr = 8'd4; data_in = 32'h77; byte_en = 4'hF; wr = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("async_seg", seg_out, 32'h0);
        check("async_sen", seg_en, 32'h0);
        check("async_irq", {31'h0, btn_irq}, 32'h0);
        @(negedge clk); #1 wr = 1'b0; byte_en = '0;
        @(posedge clk); #1 rst_n = 1'b1;
        step();
        rd("cyc_dropped", 4, 32'd1);
        rd("ram_kept", 10, 32'hAA22CC44);

        // Randomized traffic against the model
        for (int it = 0; it < 600; it++) begin
            @(posedge clk); #1;
            if ($urandom_range(0, 3) == 0)
                buttons_in[$urandom_range(0, 15)] ^= 1'b1;
            wr = ($urandom_range(0, 1) == 1);
            a = int'($urandom_range(0, 12));
            d_addr = 8'(a);
            data_in = $urandom;
            byte_en = 4'($urandom_range(0, 15));
            #1;
            kn = (a <= 4) ? 32'hFFFFFFFF : m_kn[a];
            if (kn != 0)
                check("rnd_rd", data_out & kn, m_read(a) & kn);
            check("rnd_seg", seg_out, m_seg);
            check("rnd_sen", seg_en, m_sen);
            check("rnd_irq", {31'h0, btn_irq}, {31'h0, |m_edge});
        end
        @(posedge clk); #1 wr = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
